oqpsk_axis_ingress: RTL
=======================

Name: oqpsk_axis_ingress

Overview:
AXI4-Stream slave ingress stage directly upstream of the in-phase/quadrature symbol FSMs. It buffers incoming TDATA words in a small FIFO and presents the head word to the bit-slicing datapath. It generates the start_fsms enable and the last_packet flag, and pops a word each time the FSMs report the last sample of a packet. It stalls the FSMs (start_fsms low) on underrun and returns to idle after end_of_transmission.

Parameters:
C_S00_AXIS_TDATA_WIDTH, 16, width of one stream word; the FSMs consume C_S00_AXIS_TDATA_WIDTH/2 symbols per word.
BURST_SIZE, 2, FIFO depth in words and prime threshold; power of two, at least 2.

Ports:
aclk  in  1  clock, rising edge
areset  in  1  asynchronous, active-high reset
s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  stream payload
s00_axis_tvalid  in  1  payload valid
s00_axis_tlast  in  1  final word of transmission
s00_axis_tready  out  1  ingress can accept a word
last_sample_of_packet  in  1  from the FSMs: head word fully consumed this cycle
end_of_transmission  in  1  from the FSMs: offset tail finished
start_fsms  out  1  enables the FSM counters
last_packet  out  1  head word carries tlast
packet_data  out  C_S00_AXIS_TDATA_WIDTH  head word, held stable while not popped
underrun  out  1  sticky: FIFO empty while the FSMs needed data

Behaviour:
- Reset (async assert, release synchronous to aclk): FIFO empty, state IDLE; s00_axis_tready=0, start_fsms=0, last_packet=0, packet_data=0, underrun=0.
- FIFO: BURST_SIZE entries of {tlast, tdata}; read/write pointers of $clog2(BURST_SIZE) bits that wrap; occupancy count of $clog2(BURST_SIZE)+1 bits.
- Push occurs when s00_axis_tvalid && s00_axis_tready.
- s00_axis_tready = !full && !tlast_seen && state != DRAIN_WAIT.
- Pop occurs when start_fsms && last_sample_of_packet && !empty.
- Push and pop in the same cycle when full: the pop frees the slot, but tready is computed from registered state, so there is no push that cycle (no combinational tready-from-pop path).
- packet_data and last_packet come from the FIFO head, registered. They update on the cycle after a pop and are 0 when the FIFO is empty.
- States:
  - IDLE: tready follows the rule above. Go to PRIME on the first push.
  - PRIME: go to RUN when the FIFO is full, or when a word with tlast has been pushed.
  - RUN: start_fsms=1 while the FIFO is not empty. Popping the tlast word goes to DRAIN_WAIT. If last_sample_of_packet arrives while empty: set underrun, start_fsms=0 (the FSMs hold in IDLE), stay in RUN; start_fsms reasserts one cycle after the next push.
  - DRAIN_WAIT: start_fsms=1 so the FSMs finish the offset tail; no pops, no pushes. end_of_transmission=1 clears tlast_seen and goes to IDLE the next cycle with start_fsms=0.
- tlast_seen is set on a push with tlast and cleared on exit from DRAIN_WAIT. Words after tlast are back-pressured until IDLE.
- Latency: first word accepted to start_fsms high is 1 cycle once the prime condition is met.
- Single-word transmission (tlast on the first word): PRIME to RUN immediately.
- areset mid-transmission discards the FIFO contents and clears underrun.
- underrun clears only on reset.

Decomposition:
- Shared package typedefs.sv: ingress_state_t {IDLE, PRIME, RUN, DRAIN_WAIT}, alongside the existing transmission_state_t.
- One sub-module: axis_sync_fifo (parameters DATA_WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count), instantiated with DATA_WIDTH = C_S00_AXIS_TDATA_WIDTH+1.

Test Plan:
- Reset, then push 0xA5A5 and 0x3C3C (no tlast), BURST_SIZE=2 -> start_fsms rises the cycle after the 2nd push; packet_data=0xA5A5; tready=0 while full.
- Pulse last_sample_of_packet once -> the next cycle packet_data=0x3C3C and tready=1.
- Push 0x1234 with tlast -> last_packet=1 when it reaches the head; its pop enters DRAIN_WAIT; tready stays 0.
- In DRAIN_WAIT, drive end_of_transmission=1 for 1 cycle -> the next cycle state=IDLE, start_fsms=0, tready=1.
- Let the FIFO empty, then pulse last_sample_of_packet -> underrun=1 sticky, start_fsms=0. Push 0x00FF -> start_fsms=1 one cycle later.
- Assert areset asynchronously mid-RUN with 2 words buffered -> all outputs 0 immediately; after release, a new single tlast word primes and runs.

Source files
------------

// File: rtl/oqpsk_axis_ingress_pkg.sv
// Shared types for the O-QPSK transmit path.
package oqpsk_axis_ingress_pkg;

  // Ingress sequencing in front of the I/Q symbol FSMs.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRIME      = 2'd1,
    RUN        = 2'd2,
    DRAIN_WAIT = 2'd3
  } ingress_state_t;

  // Symbol FSM sequencing as seen by the modulator core.
  typedef enum logic [1:0] {
    TX_IDLE        = 2'd0,
    TX_BUSY        = 2'd1,
    TX_OFFSET_TAIL = 2'd2
  } transmission_state_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// Small synchronous FIFO with a registered head word (zero when empty).
module axis_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 17,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_dout;

  logic                  w_push;
  logic                  w_pop;
  logic [PTR_W-1:0]      w_rd_next;
  logic [CNT_W-1:0]      w_count_next;
  logic [DATA_WIDTH-1:0] w_dout_next;

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_dout;
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Head word as it will be after this edge; a push lands at the head when
  // the FIFO is empty or the only stored word is being popped.
  always_comb begin
    w_rd_next    = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
    w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_dout_next  = '0;
    if (w_count_next != '0) begin
      if (w_push && ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop))) begin
        w_dout_next = din;
      end else begin
        w_dout_next = r_mem[w_rd_next];
      end
    end
  end

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_dout   <= w_dout_next;
    end
  end

endmodule

// File: rtl/oqpsk_axis_ingress.sv
// AXI4-Stream ingress: buffers words for the I/Q symbol FSMs and sequences them.
module oqpsk_axis_ingress
  import oqpsk_axis_ingress_pkg::*;
#(
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 16,
  parameter int unsigned BURST_SIZE             = 2
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                              s00_axis_tvalid,
  input  logic                              s00_axis_tlast,
  output logic                              s00_axis_tready,
  input  logic                              last_sample_of_packet,
  input  logic                              end_of_transmission,
  output logic                              start_fsms,
  output logic                              last_packet,
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0] packet_data,
  output logic                              underrun
);

  localparam int unsigned DATA_W = C_S00_AXIS_TDATA_WIDTH + 1;
  localparam int unsigned CNT_W  = $clog2(BURST_SIZE) + 1;

  ingress_state_t    r_state;
  ingress_state_t    w_state_next;
  logic              r_tready;
  logic              r_start_fsms;
  logic              r_underrun;
  logic              r_tlast_seen;
  logic              w_tready_next;
  logic              w_start_next;
  logic              w_underrun_next;
  logic              w_tlast_seen_next;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_count_next;
  logic [DATA_W-1:0] w_head;

  assign w_push       = s00_axis_tvalid && r_tready && !w_full;
  assign w_pop        = r_start_fsms && last_sample_of_packet && !w_empty;
  assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

  assign s00_axis_tready = r_tready;
  assign start_fsms      = r_start_fsms;
  assign underrun        = r_underrun;
  assign packet_data     = w_head[C_S00_AXIS_TDATA_WIDTH-1:0];
  assign last_packet     = w_head[DATA_W-1];

  axis_sync_fifo #(
    .DATA_WIDTH (DATA_W),
    .DEPTH      (BURST_SIZE)
  ) u_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({s00_axis_tlast, s00_axis_tdata}),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Next state plus next values of the registered handshake/enable outputs.
  always_comb begin
    w_state_next      = r_state;
    w_tlast_seen_next = r_tlast_seen;
    w_underrun_next   = r_underrun;
    if (w_push && s00_axis_tlast) begin
      w_tlast_seen_next = 1'b1;
    end
    case (r_state)
      IDLE: begin
        if (w_push) begin
          w_state_next = PRIME;
        end
      end
      PRIME: begin
        if ((w_count_next == CNT_W'(BURST_SIZE)) || w_tlast_seen_next) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_pop && w_head[DATA_W-1]) begin
          w_state_next = DRAIN_WAIT;
        end
        if (last_sample_of_packet && w_empty) begin
          w_underrun_next = 1'b1;
        end
      end
      DRAIN_WAIT: begin
        if (end_of_transmission) begin
          w_state_next      = IDLE;
          w_tlast_seen_next = 1'b0;
        end
      end
      default: w_state_next = IDLE;
    endcase
    w_tready_next = (w_count_next != CNT_W'(BURST_SIZE)) && !w_tlast_seen_next
                    && (w_state_next != DRAIN_WAIT);
    w_start_next  = ((w_state_next == RUN) && (w_count_next != '0))
                    || (w_state_next == DRAIN_WAIT);
  end

  // State and output registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state      <= IDLE;
      r_tlast_seen <= 1'b0;
      r_underrun   <= 1'b0;
      r_tready     <= 1'b0;
      r_start_fsms <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_tlast_seen <= w_tlast_seen_next;
      r_underrun   <= w_underrun_next;
      r_tready     <= w_tready_next;
      r_start_fsms <= w_start_next;
    end
  end

endmodule
